// File: rtl/counter_sample_fifo.sv
// Sample capture FIFO for the 8-bit accumulating counter.
// Captures q on edges where q_vld=1 into a first-word-fall-through FIFO, presents
// samples on a valid/ready handshake and raises a sticky overflow on dropped samples.
// Optional macro COUNTER_SAMPLE_FIFO_DELTA_EN stores (q - prev) instead of raw q.
module counter_sample_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic [WIDTH-1:0]         q,
    input  logic                     q_vld,
    output logic [WIDTH-1:0]         dout,
    output logic                     dout_vld,
    input  logic                     dout_rdy,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          ovf_q, ovf_d;

    logic             full;
    logic             push;
    logic             pop;
    logic             drop;
    logic [WIDTH-1:0] wr_data;

    assign full     = (level_q == LW'(DEPTH));
    assign dout_vld = (level_q != '0);
    assign pop      = dout_vld & dout_rdy;
    // A full FIFO still accepts a sample when the head leaves on the same edge.
    assign push     = q_vld & (~full | pop);
    assign drop     = q_vld & full & ~pop;

`ifdef COUNTER_SAMPLE_FIFO_DELTA_EN
    logic [WIDTH-1:0] prev_q, prev_d;

    assign wr_data = q - prev_q;

    // Delta reference tracks the last accepted raw sample; drops leave it alone.
    always_comb begin
        prev_d = prev_q;
        if (clr) begin
            prev_d = '0;
        end else if (push) begin
            prev_d = q;
        end
    end

    // Delta reference register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
        end else begin
            prev_q <= prev_d;
        end
    end
`else
    assign wr_data = q;
`endif

    // Pointer, level and overflow next-state; clr overrides every other event.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
            if (drop) begin
                ovf_d = 1'b1;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    // Sample storage; never reset or flushed, only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign dout  = mem[rd_ptr_q];
    assign level = level_q;
    assign ovf   = ovf_q;

endmodule
